// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer
// ----------------------------------------------------------------------------
// Moore control unit that sequences one register-register ALU instruction
// through the CPU datapath for every accepted start pulse:
//   fetch     T0 .. T2   (T1 waits for memory, with a timeout)
//   operand   T3 .. T4
//   writeback T5 [, T6]
// Each output is a register. Its value is decoded from the next state, so a
// control line is valid for the whole cycle of the state it belongs to.
//
// Instruction fields come from the datapath IR:
//   op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]
//
// Build option:
//   ALU_MULDIV_EN  defined   -> mul (01111) and div (10000) are legal. T4 also
//                               loads ZHI. T5 moves ZLO->LO and T6 moves
//                               ZHI->HI. No general register is written.
//   ALU_MULDIV_EN  undefined -> mul/div are illegal opcodes. There is no T6.
//                               HIin, Loin and ZHIin are tied low.
//
// Parameters:
//   MEM_TIMEOUT  cycles spent in T1 without mem_rdy before abort (1..255)
//
// Ports:
//   clk           in   clock, rising-edge
//   clr           in   synchronous reset, active-low
//   start         in   begin one instruction (sampled only in IDLE)
//   mem_rdy       in   memory read data valid
//   ir[31:0]      in   IR contents from the datapath
//   PCout .. Loin out  datapath enables, one bit each
//   Rout[15:0]    out  one-hot register-to-bus select
//   Rin[15:0]     out  one-hot register load enable
//   ALUSelection  out  ALU opcode, non-zero only in T4
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse in the final writeback cycle
//   err           out  sticky error: illegal opcode or memory timeout
// ============================================================================
module alu_op_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 32'd16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Yout,
    output logic        Zin,
    output logic        ZLOin,
    output logic        ZHIin,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        HIin,
    output logic        Loin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  ALUSelection,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // The timer holds the number of completed T1 cycles. Leaving on this
    // value makes T1 last exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST_C = 8'(MEM_TIMEOUT - 32'd1);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
`ifdef ALU_MULDIV_EN
        ,
        S_T6   = 3'd7
`endif
    } state_t;

    // Control lines that exist in every build. ZHIin, HIin and Loin are
    // handled separately because they only exist with mul/div enabled.
    typedef struct packed {
        logic        pc_out;
        logic        mar_in;
        logic        inc_pc;
        logic        pc_in;
        logic        read;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        y_out;
        logic        z_in;
        logic        zlo_in;
        logic        zlo_out;
        logic        zhi_out;
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic [4:0]  alu_sel;
        logic        busy;
        logic        done;
    } ctl_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        reg_onehot = 16'h0001 << idx;
    endfunction

    function automatic logic op_is_unary(input logic [4:0] op);
        op_is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

`ifdef ALU_MULDIV_EN
    function automatic logic op_is_muldiv(input logic [4:0] op);
        op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction
`endif

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_NEG, OP_NOT:  op_is_legal = 1'b1;
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIV:  op_is_legal = 1'b1;
`endif
            default:         op_is_legal = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  timer_r;
    logic [7:0]  timer_nxt_s;
    logic        err_r;
    logic        err_nxt_s;
    ctl_t        ctl_r;
    ctl_t        ctl_nxt_s;

    logic [4:0]  op_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        ir_unused_s;

    assign op_s        = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign ir_unused_s = ^ir[14:0];

`ifdef ALU_MULDIV_EN
    logic zhi_in_r;
    logic zhi_in_nxt_s;
    logic hi_in_r;
    logic hi_in_nxt_s;
    logic lo_in_r;
    logic lo_in_nxt_s;
`endif

    // Next-state, memory-wait timer and sticky error.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        err_nxt_s   = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_T0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_T0: begin
                state_nxt_s = S_T1;
                timer_nxt_s = 8'd0;
            end
            S_T1: begin
                if (mem_rdy) begin
                    state_nxt_s = S_T2;
                    timer_nxt_s = 8'd0;
                end else if (timer_r >= TIMEOUT_LAST_C) begin
                    state_nxt_s = S_IDLE;
                    timer_nxt_s = 8'd0;
                    err_nxt_s   = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + 8'd1;
                end
            end
            S_T2: begin
                // The opcode check is made here so that T3 can be decoded
                // as a dead cycle (every enable low) for an illegal opcode.
                // err was cleared on start, so in T3 it marks an illegal op.
                state_nxt_s = S_T3;
                if (op_is_legal(op_s)) begin
                    err_nxt_s = err_r;
                end else begin
                    err_nxt_s = 1'b1;
                end
            end
            S_T3: begin
                if (err_r) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_T4;
                end
            end
            S_T4: begin
                state_nxt_s = S_T5;
            end
            S_T5: begin
`ifdef ALU_MULDIV_EN
                if (op_is_muldiv(op_s)) begin
                    state_nxt_s = S_T6;
                end else begin
                    state_nxt_s = S_IDLE;
                end
`else
                state_nxt_s = S_IDLE;
`endif
            end
`ifdef ALU_MULDIV_EN
            S_T6: begin
                state_nxt_s = S_IDLE;
            end
`endif
            default: begin
                state_nxt_s = S_IDLE;
                timer_nxt_s = 8'd0;
            end
        endcase
    end

    // Decode the control lines for the state being entered.
    always_comb begin
        ctl_nxt_s      = '0;
        ctl_nxt_s.busy = (state_nxt_s != S_IDLE);
`ifdef ALU_MULDIV_EN
        zhi_in_nxt_s   = 1'b0;
        hi_in_nxt_s    = 1'b0;
        lo_in_nxt_s    = 1'b0;
`endif
        case (state_nxt_s)
            S_IDLE: begin
                ctl_nxt_s.busy = 1'b0;
            end
            S_T0: begin
                ctl_nxt_s.pc_out = 1'b1;
                ctl_nxt_s.mar_in = 1'b1;
                ctl_nxt_s.inc_pc = 1'b1;
                ctl_nxt_s.z_in   = 1'b1;
                ctl_nxt_s.zlo_in = 1'b1;
            end
            S_T1: begin
                ctl_nxt_s.zlo_out = 1'b1;
                ctl_nxt_s.pc_in   = 1'b1;
                ctl_nxt_s.read    = 1'b1;
                ctl_nxt_s.mdr_in  = 1'b1;
            end
            S_T2: begin
                ctl_nxt_s.mdr_out = 1'b1;
                ctl_nxt_s.ir_in   = 1'b1;
            end
            S_T3: begin
                if (!err_nxt_s) begin
                    ctl_nxt_s.r_out = reg_onehot(rb_s);
                    ctl_nxt_s.y_in  = 1'b1;
                end else begin
                    ctl_nxt_s.r_out = 16'h0000;
                    ctl_nxt_s.y_in  = 1'b0;
                end
            end
            S_T4: begin
                ctl_nxt_s.y_out   = 1'b1;
                ctl_nxt_s.z_in    = 1'b1;
                ctl_nxt_s.zlo_in  = 1'b1;
                ctl_nxt_s.alu_sel = op_s;
                // Unary ops take their only operand from Rb.
                if (op_is_unary(op_s)) begin
                    ctl_nxt_s.r_out = reg_onehot(rb_s);
                end else begin
                    ctl_nxt_s.r_out = reg_onehot(rc_s);
                end
`ifdef ALU_MULDIV_EN
                zhi_in_nxt_s = 1'b1;
`endif
            end
            S_T5: begin
                ctl_nxt_s.zlo_out = 1'b1;
`ifdef ALU_MULDIV_EN
                if (op_is_muldiv(op_s)) begin
                    lo_in_nxt_s = 1'b1;
                end else begin
                    ctl_nxt_s.r_in = reg_onehot(ra_s);
                    ctl_nxt_s.done = 1'b1;
                end
`else
                ctl_nxt_s.r_in = reg_onehot(ra_s);
                ctl_nxt_s.done = 1'b1;
`endif
            end
`ifdef ALU_MULDIV_EN
            S_T6: begin
                ctl_nxt_s.zhi_out = 1'b1;
                ctl_nxt_s.done    = 1'b1;
                hi_in_nxt_s       = 1'b1;
            end
`endif
            default: begin
                ctl_nxt_s = '0;
            end
        endcase
    end

    // State, timer, error and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r  <= S_IDLE;
            timer_r  <= 8'd0;
            err_r    <= 1'b0;
            ctl_r    <= '0;
`ifdef ALU_MULDIV_EN
            zhi_in_r <= 1'b0;
            hi_in_r  <= 1'b0;
            lo_in_r  <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            err_r    <= err_nxt_s;
            ctl_r    <= ctl_nxt_s;
`ifdef ALU_MULDIV_EN
            zhi_in_r <= zhi_in_nxt_s;
            hi_in_r  <= hi_in_nxt_s;
            lo_in_r  <= lo_in_nxt_s;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign PCout        = ctl_r.pc_out;
    assign MARin        = ctl_r.mar_in;
    assign IncPC        = ctl_r.inc_pc;
    assign PCin         = ctl_r.pc_in;
    assign Read         = ctl_r.read;
    assign MDRin        = ctl_r.mdr_in;
    assign MDRout       = ctl_r.mdr_out;
    assign IRin         = ctl_r.ir_in;
    assign Yin          = ctl_r.y_in;
    assign Yout         = ctl_r.y_out;
    assign Zin          = ctl_r.z_in;
    assign ZLOin        = ctl_r.zlo_in;
    assign ZLOout       = ctl_r.zlo_out;
    assign ZHIout       = ctl_r.zhi_out;
    assign Rout         = ctl_r.r_out;
    assign Rin          = ctl_r.r_in;
    assign ALUSelection = ctl_r.alu_sel;
    assign busy         = ctl_r.busy;
    assign done         = ctl_r.done;
    assign err          = err_r;

`ifdef ALU_MULDIV_EN
    assign ZHIin = zhi_in_r;
    assign HIin  = hi_in_r;
    assign Loin  = lo_in_r;
`else
    assign ZHIin = 1'b0;
    assign HIin  = 1'b0;
    assign Loin  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. A small behavioural datapath is
// driven by the sequencer's control lines, so register results can be checked
// as well as the per-cycle control vectors.
module tb_alu_op_sequencer;

    localparam int MEM_TO = 16;

    logic        clk = 1'b0;
    logic        clr, start, mem_rdy;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Yout;
    logic        Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, busy, done, err;
    logic [15:0] Rout, Rin;
    logic [4:0]  ALUSelection;

    always #5 clk = ~clk;

    alu_op_sequencer #(.MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Yout(Yout),
        .Zin(Zin), .ZLOin(ZLOin), .ZHIin(ZHIin), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .HIin(HIin), .Loin(Loin), .Rout(Rout), .Rin(Rin),
        .ALUSelection(ALUSelection), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, y_out;
        logic z_in, zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in;
        logic [15:0] r_out, r_in;
        logic [4:0]  alu;
        logic busy, done, err;
    } ctl_t;

    ctl_t act;
    assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Yout,
                  Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, Rout, Rin,
                  ALUSelection, busy, done, err};

    // ---------------- behavioural datapath ----------------
    logic [31:0] rf [16];
    logic [31:0] pc_m, y_m, zlo_m, zhi_m, hi_m, lo_m, bus_s;
    logic [63:0] alu_s;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;

    always_comb begin
        bus_s = 32'd0;
        for (int k = 0; k < 16; k++) if (Rout[k]) bus_s = bus_s | rf[k];
        if (ZLOout) bus_s = bus_s | zlo_m;
        if (ZHIout) bus_s = bus_s | zhi_m;
        if (PCout)  bus_s = bus_s | pc_m;
    end

    always_comb begin
        case (ALUSelection)
            5'd3:    alu_s = {32'd0, y_m + bus_s};
            5'd4:    alu_s = {32'd0, y_m - bus_s};
            5'd5:    alu_s = {32'd0, y_m & bus_s};
            5'd6:    alu_s = {32'd0, y_m | bus_s};
            5'd15:   alu_s = {32'd0, y_m} * {32'd0, bus_s};
            5'd17:   alu_s = {32'd0, 32'd0 - bus_s};
            5'd18:   alu_s = {32'd0, ~bus_s};
            default: alu_s = IncPC ? {32'd0, bus_s + 32'd1} : 64'd0;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en) begin
            rf[ld_idx] <= ld_val;
        end else begin
            if (Yin)   y_m   <= bus_s;
            if (ZLOin) zlo_m <= alu_s[31:0];
            if (ZHIin) zhi_m <= alu_s[63:32];
            if (PCin)  pc_m  <= bus_s;
            if (HIin)  hi_m  <= bus_s;
            if (Loin)  lo_m  <= bus_s;
            for (int k = 0; k < 16; k++) if (Rin[k]) rf[k] <= bus_s;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;
    ctl_t q[$];

    task automatic chk_vec(input string name, input int cyc, input ctl_t got, input ctl_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic bit is_md(input logic [4:0] op);
`ifdef ALU_MULDIV_EN
        return (op == 5'd15) || (op == 5'd16);
`else
        return (op == 5'd31) && (op == 5'd0);
`endif
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return ((op >= 5'd3) && (op <= 5'd11)) || (op == 5'd17) || (op == 5'd18) || is_md(op);
    endfunction

    // Expected control vector; st: 0 IDLE, 1 T0, 2 T1, ... 7 T6.
    function automatic ctl_t exp_vec(input int st, input logic [31:0] i, input bit e);
        ctl_t c;
        logic [4:0] op;
        op = i[31:27];
        c = '0;
        c.err = e;
        c.busy = (st != 0);
        case (st)
            1: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; c.zlo_in = 1'b1; end
            2: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            3: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            4: begin c.r_out = 16'd1 << i[22:19]; c.y_in = 1'b1; end
            5: begin
                c.y_out = 1'b1; c.z_in = 1'b1; c.zlo_in = 1'b1; c.alu = op;
                c.r_out = ((op == 5'd17) || (op == 5'd18)) ? (16'd1 << i[22:19]) : (16'd1 << i[18:15]);
`ifdef ALU_MULDIV_EN
                c.zhi_in = 1'b1;
`endif
            end
            6: begin
                c.zlo_out = 1'b1;
                if (is_md(op)) c.lo_in = 1'b1;
                else begin c.r_in = 16'd1 << i[26:23]; c.done = 1'b1; end
            end
            7: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; c.done = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic push_instr(input logic [31:0] i, input int nlow);
        ctl_t c;
        q.push_back(exp_vec(1, i, 1'b0));
        if (nlow >= MEM_TO) begin
            repeat (MEM_TO) q.push_back(exp_vec(2, i, 1'b0));
            q.push_back(exp_vec(0, i, 1'b1));
            q.push_back(exp_vec(0, i, 1'b1));
            return;
        end
        repeat (nlow + 1) q.push_back(exp_vec(2, i, 1'b0));
        q.push_back(exp_vec(3, i, 1'b0));
        if (!is_legal(i[31:27])) begin
            c = exp_vec(0, i, 1'b1);
            c.busy = 1'b1;
            q.push_back(c);
            q.push_back(exp_vec(0, i, 1'b1));
            q.push_back(exp_vec(0, i, 1'b1));
            return;
        end
        q.push_back(exp_vec(4, i, 1'b0));
        q.push_back(exp_vec(5, i, 1'b0));
        q.push_back(exp_vec(6, i, 1'b0));
        if (is_md(i[31:27])) q.push_back(exp_vec(7, i, 1'b0));
        q.push_back(exp_vec(0, i, 1'b0));
        q.push_back(exp_vec(0, i, 1'b0));
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        ld_idx = idx; ld_val = val; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Start one instruction and compare every cycle until the queue drains.
    task automatic run_instr(input logic [31:0] i, input int nlow, input bit poke, output int done_cyc);
        int cyc;
        ctl_t want;
        ir = i;
        push_instr(i, nlow);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        done_cyc = 0;
        while (q.size() > 0) begin
            mem_rdy = (cyc >= 2 + nlow);
            start = poke && (cyc >= 2) && (cyc <= 4);
            want = q.pop_front();
            chk_vec("ctl", cyc, act, want);
            if (act.done === 1'b1) done_cyc = cyc;
            if (q.size() > 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        mem_rdy = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ir;
        int          nlow;
        logic [31:0] r2, r3;
        bit          ok;
        logic [31:0] val;
        int          lat;
        bit          poke;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int dc;
        logic [3:0] dst;
        logic [31:0] prev;

        tbl[0] = '{32'h28918000, 0,  32'h0A, 32'h02, 1'b1, 32'h00000002, 6,  1'b1};
        tbl[1] = '{32'h18918000, 3,  32'h0A, 32'h02, 1'b1, 32'h0000000C, 9,  1'b0};
        tbl[2] = '{32'h88918000, 1,  32'h0A, 32'h02, 1'b1, 32'hFFFFFFF6, 7,  1'b0};
        tbl[3] = '{32'h30918000, 0,  32'h0A, 32'h02, 1'b1, 32'h0000000A, 6,  1'b0};
        tbl[4] = '{32'h20918000, 15, 32'h0A, 32'h02, 1'b1, 32'h00000008, 21, 1'b0};
        tbl[5] = '{32'h19110000, 0,  32'h05, 32'h02, 1'b1, 32'h0000000A, 6,  1'b0};
        tbl[6] = '{32'hF8918000, 0,  32'h0A, 32'h02, 1'b0, 32'h0,        0,  1'b1};
        tbl[7] = '{32'h90918000, 0,  32'h0A, 32'h02, 1'b1, 32'hFFFFFFF5, 6,  1'b0};
        tbl[8] = '{32'h18918000, 16, 32'h0A, 32'h02, 1'b0, 32'h0,        0,  1'b0};
        tbl[9] = '{32'h28918000, 0,  32'hFF, 32'h0F, 1'b1, 32'h0000000F, 6,  1'b0};

        clr = 1'b0; start = 1'b0; mem_rdy = 1'b0; ir = 32'd0;
        ld_en = 1'b0; ld_idx = 4'd0; ld_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_vec("reset", 0, act, '0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk_vec("idle_after_reset", 0, act, '0);

        for (int v = 0; v < 10; v++) begin
            preload(4'd1, 32'hDEADBEEF);
            preload(4'd2, tbl[v].r2);
            preload(4'd3, tbl[v].r3);
            dst = tbl[v].ir[26:23];
            prev = rf[dst];
            run_instr(tbl[v].ir, tbl[v].nlow, tbl[v].poke, dc);
            chk_val($sformatf("latency_v%0d", v), dc, tbl[v].lat);
            chk_val($sformatf("dest_v%0d", v), rf[dst], tbl[v].ok ? tbl[v].val : prev);
            chk_val($sformatf("err_v%0d", v), {31'd0, err}, {31'd0, !tbl[v].ok});
        end

        // clr asserted while an AND sits in T4
        preload(4'd1, 32'h00000055);
        ir = 32'h28918000;
        mem_rdy = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_vec("pre_clr_t4", 5, act, exp_vec(5, ir, 1'b0));
        clr = 1'b0;
        @(posedge clk); #1;
        chk_vec("clr_mid_t4", 6, act, '0);
        clr = 1'b1;
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        chk_vec("idle_after_clr", 7, act, '0);
        chk_val("r1_after_clr", rf[1], 32'h00000055);

        // mul: HI/LO writeback when enabled, illegal otherwise
        preload(4'd2, 32'h00010000);
        preload(4'd3, 32'h00010000);
        run_instr(32'h78918000, 0, 1'b0, dc);
`ifdef ALU_MULDIV_EN
        chk_val("mul_latency", dc, 32'd7);
        chk_val("mul_lo", lo_m, 32'h0);
        chk_val("mul_hi", hi_m, 32'h1);
        chk_val("mul_err", {31'd0, err}, 32'd0);
`else
        chk_val("mul_latency", dc, 32'd0);
        chk_val("mul_err", {31'd0, err}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
